mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 162 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// mult/multu/div/divu occupy the unit for a fixed number of cycles and then
// commit to HI/LO in one step; mthi/mtlo write immediately when idle.
// While busy, new requests are dropped; the hazard unit stalls on Start_E|Busy.
//
// Handshake: there is no ready signal. A request is Start_E=1 with a valid
// MDOP_E, and it is accepted only on an edge where the unit is IDLE. Busy is
// high from the cycle after an accepted mult/div launch until the commit edge.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start_E,
    input  logic [2:0]  MDOP_E,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic        HILO_SEL_E,
    output logic [31:0] MUDI_OUT_E,
    output logic        Busy,
    output logic        dbg_state
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // Initialisers give a defined all-zero state at time zero in simulation.
    state_t        state = IDLE;
    state_t        state_next;
    logic [31:0]   hi    = '0;
    logic [31:0]   lo    = '0;
    logic [31:0]   op_a  = '0;
    logic [31:0]   op_b  = '0;
    logic [2:0]    op    = '0;
    logic [CW-1:0] cnt   = '0;

    logic launch;
    logic finish;
    logic mthi_we;
    logic mtlo_we;

    // Datapath for the latched operation.
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_signed;
    logic        [31:0] mag_a;
    logic        [31:0] mag_b;
    logic        [31:0] divisor;
    logic        [31:0] q_mag;
    logic        [31:0] r_mag;
    logic        [31:0] res_hi;
    logic        [31:0] res_lo;
    logic               res_valid;

    assign Busy       = (state == BUSY);
    assign dbg_state  = state;
    assign MUDI_OUT_E = HILO_SEL_E ? lo : hi;

    assign prod_s = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
    assign prod_u = {32'd0, op_a} * {32'd0, op_b};

    // Signed division is done on magnitudes so the -2^31 / -1 corner needs no
    // special case: the magnitude quotient 0x80000000 re-signs to itself.
    assign div_signed = (op == 3'd2);
    assign mag_a      = (div_signed && op_a[31]) ? (32'd0 - op_a) : op_a;
    assign mag_b      = (div_signed && op_b[31]) ? (32'd0 - op_b) : op_b;
    assign divisor    = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign q_mag      = mag_a / divisor;
    assign r_mag      = mag_a % divisor;

    // Select the commit value for the latched op; a zero divisor commits nothing.
    always_comb begin
        res_hi    = hi;
        res_lo    = lo;
        res_valid = 1'b0;
        case (op)
            3'd0: begin
                res_hi    = prod_s[63:32];
                res_lo    = prod_s[31:0];
                res_valid = 1'b1;
            end
            3'd1: begin
                res_hi    = prod_u[63:32];
                res_lo    = prod_u[31:0];
                res_valid = 1'b1;
            end
            3'd2, 3'd3: begin
                res_lo    = (div_signed && (op_a[31] ^ op_b[31])) ? (32'd0 - q_mag) : q_mag;
                res_hi    = (div_signed && op_a[31]) ? (32'd0 - r_mag) : r_mag;
                res_valid = (op_b != 32'd0);
            end
            default: ;
        endcase
    end

    // Next-state logic and per-edge strobes; requests only count when idle.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        finish     = 1'b0;
        mthi_we    = 1'b0;
        mtlo_we    = 1'b0;
        case (state)
            IDLE: begin
                if (Start_E) begin
                    if (!MDOP_E[2]) begin
                        launch     = 1'b1;
                        state_next = BUSY;
                    end else if (MDOP_E == 3'd4) begin
                        mthi_we = 1'b1;
                    end else if (MDOP_E == 3'd5) begin
                        mtlo_we = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt == CW'(1)) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset wins over any launch or completion.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Operand latch, cycle counter and HI/LO updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi   <= '0;
            lo   <= '0;
            op_a <= '0;
            op_b <= '0;
            op   <= '0;
            cnt  <= '0;
        end else begin
            if (launch) begin
                op_a <= RD1_E;
                op_b <= RD2_E;
                op   <= MDOP_E;
                cnt  <= MDOP_E[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (state == BUSY) begin
                cnt <= cnt - CW'(1);
            end
            if (mthi_we) hi <= RD1_E;
            if (mtlo_we) lo <= RD1_E;
            if (finish && res_valid) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: a cycle-level arithmetic model checked every cycle,
// directed cases with literal expectations, then randomized traffic.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Start_E = 1'b0;
    logic [2:0]  MDOP_E = 3'd0;
    logic [31:0] RD1_E = 32'd0;
    logic [31:0] RD2_E = 32'd0;
    logic        HILO_SEL_E = 1'b0;
    logic [31:0] MUDI_OUT_E;
    logic        Busy;
    logic        dbg_state;

    int total = 0;
    int bad   = 0;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .Start_E(Start_E), .MDOP_E(MDOP_E),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .HILO_SEL_E(HILO_SEL_E),
        .MUDI_OUT_E(MUDI_OUT_E), .Busy(Busy), .dbg_state(dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural HI/LO plus remaining busy cycles and a
    // pending result that lands when the remaining count runs out.
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    int          m_left = 0;
    bit          m_wr = 0;

    always @(posedge clk) begin
        longint sa, sb;
        logic [63:0] p;
        if (rst) begin
            m_hi = 0; m_lo = 0; m_left = 0; m_wr = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_wr) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (Start_E) begin
            sa = longint'($signed(RD1_E));
            sb = longint'($signed(RD2_E));
            case (MDOP_E)
                3'd0: begin p = 64'(sa * sb); p_hi = p[63:32]; p_lo = p[31:0]; m_wr = 1; m_left = MC; end
                3'd1: begin p = {32'd0, RD1_E} * {32'd0, RD2_E}; p_hi = p[63:32]; p_lo = p[31:0]; m_wr = 1; m_left = MC; end
                3'd2: begin
                    m_wr = (RD2_E != 0); m_left = DC;
                    if (m_wr) begin p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); end
                end
                3'd3: begin
                    m_wr = (RD2_E != 0); m_left = DC;
                    if (m_wr) begin p_lo = RD1_E / RD2_E; p_hi = RD1_E % RD2_E; end
                end
                3'd4: m_hi = RD1_E;
                3'd5: m_lo = RD1_E;
                default: ;
            endcase
        end
    end

    // Compare outputs against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        check("busy", {31'd0, Busy}, {31'd0, m_left > 0});
        check("state", {31'd0, dbg_state}, {31'd0, m_left > 0});
        check("mudi_out", MUDI_OUT_E, HILO_SEL_E ? m_lo : m_hi);
    end

    // Driver tasks: inputs change 2 time units after the rising edge.
    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        step();
        Start_E = 1'b1; MDOP_E = op; RD1_E = a; RD2_E = b;
        step();
        Start_E = 1'b0;
    endtask

    // Counts busy cycles from the first cycle after launch; bounded.
    task automatic wait_idle(input string name, input int exp_cycles);
        int n = 0;
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (Busy) n++;
            else done = 1;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL %s_timeout: busy never dropped", name);
        end else begin
            check({name, "_cycles"}, 32'(n), 32'(exp_cycles));
        end
    endtask

    task automatic read_chk(input logic sel, input logic [31:0] exp, input string name);
        step();
        Start_E = 1'b0; HILO_SEL_E = sel;
        @(negedge clk);
        check(name, MUDI_OUT_E, exp);
    endtask

    initial begin
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        read_chk(1'b0, 32'h0, "reset_hi");
        read_chk(1'b1, 32'h0, "reset_lo");

        issue(3'd0, 32'hFFFF_FFFF, 32'h2);
        wait_idle("mult", MC);
        read_chk(1'b0, 32'hFFFF_FFFF, "mult_hi");
        read_chk(1'b1, 32'hFFFF_FFFE, "mult_lo");

        issue(3'd1, 32'hFFFF_FFFF, 32'h2);
        wait_idle("multu", MC);
        read_chk(1'b0, 32'h0000_0001, "multu_hi");
        read_chk(1'b1, 32'hFFFF_FFFE, "multu_lo");

        issue(3'd2, 32'hFFFF_FFF9, 32'h2);
        wait_idle("div", DC);
        read_chk(1'b1, 32'hFFFF_FFFD, "div_lo");
        read_chk(1'b0, 32'hFFFF_FFFF, "div_hi");

        issue(3'd3, 32'd7, 32'd2);
        wait_idle("divu", DC);
        read_chk(1'b1, 32'd3, "divu_lo");
        read_chk(1'b0, 32'd1, "divu_hi");

        // Division by zero keeps preloaded HI/LO.
        issue(3'd4, 32'h11, 32'h0);
        issue(3'd5, 32'h22, 32'h0);
        issue(3'd2, 32'h1234, 32'h0);
        wait_idle("divzero", DC);
        read_chk(1'b0, 32'h11, "divzero_hi");
        read_chk(1'b1, 32'h22, "divzero_lo");

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("divovf", DC);
        read_chk(1'b1, 32'h8000_0000, "divovf_lo");
        read_chk(1'b0, 32'h0, "divovf_hi");

        // mthi visible the next cycle.
        step();
        Start_E = 1'b1; MDOP_E = 3'd4; RD1_E = 32'h1234_5678;
        step();
        Start_E = 1'b0; HILO_SEL_E = 1'b0;
        @(negedge clk);
        check("mthi_next", MUDI_OUT_E, 32'h1234_5678);

        // mtlo during a busy mult is dropped.
        issue(3'd0, 32'd3, 32'd5);
        Start_E = 1'b1; MDOP_E = 3'd5; RD1_E = 32'hDEAD_BEEF;
        step();
        Start_E = 1'b0;
        wait_idle("mult_mtlo", MC - 1);
        read_chk(1'b1, 32'd15, "mtlo_busy_lo");

        // multu request in busy cycle 2 of a div is ignored.
        issue(3'd2, 32'd100, 32'd7);
        step();
        Start_E = 1'b1; MDOP_E = 3'd1; RD1_E = 32'hFFFF; RD2_E = 32'hFFFF;
        step();
        Start_E = 1'b0;
        wait_idle("div_relaunch", DC - 2);
        read_chk(1'b1, 32'd14, "relaunch_lo");
        read_chk(1'b0, 32'd2, "relaunch_hi");

        // Reset in busy cycle 3 discards the div.
        issue(3'd3, 32'd1000, 32'd3);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        for (int i = 0; i < DC + 3; i++) step();
        read_chk(1'b0, 32'h0, "rst_hi");
        read_chk(1'b1, 32'h0, "rst_lo");

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 600; i++) begin
            step();
            Start_E    = ($urandom_range(0, 2) != 0);
            MDOP_E     = 3'($urandom_range(0, 7));
            RD1_E      = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0: RD2_E = 32'd0;
                1: RD2_E = 32'hFFFF_FFFF;
                2: RD2_E = 32'($urandom_range(1, 20));
                default: RD2_E = $urandom;
            endcase
            HILO_SEL_E = 1'($urandom_range(0, 1));
            rst        = ($urandom_range(0, 80) == 0);
        end
        step();
        rst = 1'b0; Start_E = 1'b0;
        for (int i = 0; i < DC + 2; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
